// File: rtl/snes_video_pkg.sv
// Shared SNES/HDMI video definitions: frame-sync FSM states, default
// sync lines, the 720p raster used by the HDMI path and small helpers.
package snes_video_pkg;

    // Frame-sync controller states
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        PAUSED   = 2'd2,
        RUN      = 2'd3
    } sync_state_t;

    // SNES line on which the pause is taken (inside DRAM refresh) and the
    // line that re-arms the controller for the next frame.
    localparam logic [7:0] SYNC_LINE_DEFAULT  = 8'd2;
    localparam logic [7:0] REARM_LINE_DEFAULT = 8'd200;

    // 1280x720p60 raster (74.25 MHz pixel clock)
    localparam int H_ACTIVE = 1280;
    localparam int H_FRONT  = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BACK   = 220;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 720;
    localparam int V_FRONT  = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BACK   = 20;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Raster position at which the HDMI side flips its frame-start toggle
    localparam int SOF_CX = 256;
    localparam int SOF_CY = 24;

    // Increment that sticks at the top of a 16-bit range
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Increment that sticks at the top of an 8-bit range
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Brings a level toggle from another clock domain into clk and turns each
// flip into a single-cycle pulse. The first flop may go metastable; the
// pulse is formed only from the two later, settled stages.
module toggle_sync (
    input  logic clk,
    input  logic resetn,
    input  logic i_toggle,
    output logic o_pulse
);

    logic r_s0;
    logic r_s1;
    logic r_s2;

    // Three-stage shift of the asynchronous toggle level
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= i_toggle;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    assign o_pulse = r_s2 ^ r_s1;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Once-per-frame SNES pause controller. Holds the SNES core on SYNC_LINE
// until the HDMI raster reports frame start, with a watchdog that forces
// release after TIMEOUT cycles, lock tracking over consecutive good syncs
// and measurement of how long each pause lasted.
module frame_sync_ctrl
    import snes_video_pkg::*;
#(
    parameter logic [7:0]  SYNC_LINE   = SYNC_LINE_DEFAULT,
    parameter logic [7:0]  REARM_LINE  = REARM_LINE_DEFAULT,
    parameter logic [15:0] TIMEOUT     = 16'd40000,
    parameter int          LOCK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [7:0]  snes_line,
    input  logic        snes_refresh,
    input  logic        hdmi_sof_toggle,
    output logic        pause_snes,
    output logic        locked,
    output logic [15:0] last_wait,
    output logic [7:0]  timeout_cnt,
    output logic        timeout_pulse
);

    localparam int              GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]   LOCK_MAX = GW'(LOCK_FRAMES);
    localparam logic [15:0]     WAIT_END = TIMEOUT - 16'd1;

    sync_state_t   r_state;
    sync_state_t   w_state_next;
    logic [15:0]   r_wait;
    logic [15:0]   w_wait_next;
    logic [15:0]   r_last_wait;
    logic [15:0]   w_last_wait_next;
    logic [7:0]    r_timeout_cnt;
    logic [7:0]    w_timeout_cnt_next;
    logic [GW-1:0] r_good;
    logic [GW-1:0] w_good_next;
    logic [GW-1:0] w_good_inc;
    logic          r_locked;
    logic          w_locked_next;
    logic          r_pulse;
    logic          w_pulse_next;
    logic          r_pause;
    logic          w_pause_next;
    logic          w_sof_evt;

    // Frame-start toggle from the pixel domain, one pulse per HDMI frame.
    // The chain runs in every state so an edge seen while not paused is
    // consumed and cannot release a later pause.
    toggle_sync u_sof_sync (
        .clk      (clk),
        .resetn   (resetn),
        .i_toggle (hdmi_sof_toggle),
        .o_pulse  (w_sof_evt)
    );

    assign w_good_inc = (r_good == LOCK_MAX) ? r_good : r_good + GW'(1);

    // Next-state and next-output decode
    always_comb begin
        w_state_next       = r_state;
        w_wait_next        = r_wait;
        w_last_wait_next   = r_last_wait;
        w_timeout_cnt_next = r_timeout_cnt;
        w_good_next        = r_good;
        w_locked_next      = r_locked;
        w_pulse_next       = 1'b0;

        unique case (r_state)
            DISABLED: begin
                if (enable) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                // Frame-start events here are deliberately ignored
                if ((snes_line == SYNC_LINE) && snes_refresh) begin
                    w_state_next = PAUSED;
                    w_wait_next  = 16'd0;
                end
            end
            PAUSED: begin
                // A frame start on the last allowed cycle still counts as good
                if (w_sof_evt) begin
                    w_state_next     = RUN;
                    w_last_wait_next = sat_inc16(r_wait);
                    w_good_next      = w_good_inc;
                    w_locked_next    = (w_good_inc == LOCK_MAX);
                end else if (r_wait == WAIT_END) begin
                    w_state_next       = RUN;
                    w_pulse_next       = 1'b1;
                    w_timeout_cnt_next = sat_inc8(r_timeout_cnt);
                    w_last_wait_next   = TIMEOUT;
                    w_good_next        = '0;
                    w_locked_next      = 1'b0;
                end else begin
                    w_wait_next = sat_inc16(r_wait);
                end
            end
            RUN: begin
                // Only path back to ARMED, so one pause per SNES frame
                if (snes_line == REARM_LINE) begin
                    w_state_next = ARMED;
                end
            end
            default: begin
                w_state_next = DISABLED;
            end
        endcase

        // Disabling overrides everything; the statistics are kept
        if (!enable) begin
            w_state_next       = DISABLED;
            w_last_wait_next   = r_last_wait;
            w_timeout_cnt_next = r_timeout_cnt;
            w_good_next        = '0;
            w_locked_next      = 1'b0;
            w_pulse_next       = 1'b0;
        end

        w_pause_next = (w_state_next == PAUSED);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= DISABLED;
            r_wait        <= 16'd0;
            r_last_wait   <= 16'd0;
            r_timeout_cnt <= 8'd0;
            r_good        <= '0;
            r_locked      <= 1'b0;
            r_pulse       <= 1'b0;
            r_pause       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait        <= w_wait_next;
            r_last_wait   <= w_last_wait_next;
            r_timeout_cnt <= w_timeout_cnt_next;
            r_good        <= w_good_next;
            r_locked      <= w_locked_next;
            r_pulse       <= w_pulse_next;
            r_pause       <= w_pause_next;
        end
    end

    assign pause_snes    = r_pause;
    assign locked        = r_locked;
    assign last_wait     = r_last_wait;
    assign timeout_cnt   = r_timeout_cnt;
    assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl. A transaction-level model keeps
// the expected statistics: a sync toggled d cycles after the pause rises
// releases after d+3 cycles if that fits within TIMEOUT, otherwise the
// watchdog releases after exactly TIMEOUT cycles.
module tb_frame_sync_ctrl;

    localparam logic [15:0] T_OUT = 16'd1000;
    localparam int          LOCK  = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  snes_line = 8'd100;
    logic        snes_refresh = 1'b0;
    logic        hdmi_sof_toggle = 1'b0;
    logic        pause_snes;
    logic        locked;
    logic [15:0] last_wait;
    logic [7:0]  timeout_cnt;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_last   = 0;
    int m_tocnt  = 0;
    int m_good   = 0;
    int m_locked = 0;

    frame_sync_ctrl #(
        .SYNC_LINE   (8'd2),
        .REARM_LINE  (8'd200),
        .TIMEOUT     (T_OUT),
        .LOCK_FRAMES (LOCK)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .enable          (enable),
        .snes_line       (snes_line),
        .snes_refresh    (snes_refresh),
        .hdmi_sof_toggle (hdmi_sof_toggle),
        .pause_snes      (pause_snes),
        .locked          (locked),
        .last_wait       (last_wait),
        .timeout_cnt     (timeout_cnt),
        .timeout_pulse   (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_last = 0; m_tocnt = 0; m_good = 0; m_locked = 0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_last_wait"}, 32'(last_wait), 32'(m_last));
        check({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'(m_tocnt));
        check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    endtask

    // One full SNES frame: pause on line 2, optional toggle d cycles after
    // the pause rises (d<0: none), re-entry guard, then line sweep to re-arm.
    task automatic do_frame(input int d, input int guard, input string tag);
        int  k;
        int  hi;
        int  exp_len;
        bit  good;
        snes_line    = 8'd2;
        snes_refresh = 1'b1;
        tick;
        check({tag, "_pause_rise"}, 32'(pause_snes), 32'd1);
        k = 0;
        while (pause_snes === 1'b1 && k < int'(T_OUT) + 20) begin
            if (d >= 0 && k == d) hdmi_sof_toggle = ~hdmi_sof_toggle;
            tick;
            k++;
        end
        good = (d >= 0) && (d + 3 <= int'(T_OUT));
        if (good) begin
            exp_len  = d + 3;
            m_last   = d + 3;
            m_good   = (m_good < LOCK) ? m_good + 1 : LOCK;
            m_locked = (m_good == LOCK) ? 1 : 0;
        end else begin
            exp_len  = int'(T_OUT);
            m_last   = int'(T_OUT);
            m_tocnt  = (m_tocnt < 255) ? m_tocnt + 1 : 255;
            m_good   = 0;
            m_locked = 0;
        end
        check({tag, "_pause_len"}, 32'(k), 32'(exp_len));
        check({tag, "_timeout_pulse"}, 32'(timeout_pulse), good ? 32'd0 : 32'd1);
        check_stats(tag);
        tick;
        check({tag, "_pulse_clear"}, 32'(timeout_pulse), 32'd0);
        hi = 0;
        for (int i = 0; i < guard; i++) begin
            tick;
            hi += int'(pause_snes);
        end
        check({tag, "_no_repause"}, 32'(hi), 32'd0);
        hi = 0;
        for (int i = 3; i <= 261; i++) begin
            snes_line    = i[7:0];
            snes_refresh = (i[7:0] != 8'd2) && i[0];
            tick;
            hi += int'(pause_snes);
        end
        check({tag, "_sweep_no_pause"}, 32'(hi), 32'd0);
        $display("frame %s: d=%0d len=%0d last_wait=%0d timeout_cnt=%0d locked=%0d",
                 tag, d, k, last_wait, timeout_cnt, locked);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pause"}, 32'(pause_snes), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_last_wait"}, 32'(last_wait), 32'd0);
        check({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
        check({tag, "_timeout_pulse"}, 32'(timeout_pulse), 32'd0);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int hi;
        int d;
        // Reset state
        resetn = 1'b0;
        enable = 1'b1;
        repeat (3) tick;
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (3) tick;

        // Four good frames at d=500 -> locked after the fourth
        do_frame(500, 1000, "lock1");
        do_frame(500, 200, "lock2");
        do_frame(500, 200, "lock3");
        do_frame(500, 200, "lock4");

        // Watchdog release, then the sof-wins boundary and one past it
        do_frame(-1, 200, "timeout");
        do_frame(int'(T_OUT) - 3, 200, "sof_at_limit");
        do_frame(int'(T_OUT) - 2, 200, "sof_late");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, int'(T_OUT) + 5));
            do_frame(d, 100, $sformatf("rand%0d", f));
        end

        // Disable mid-pause
        snes_line = 8'd2; snes_refresh = 1'b1;
        tick;
        check("dis_pause_rise", 32'(pause_snes), 32'd1);
        repeat (50) tick;
        enable = 1'b0;
        tick;
        m_good = 0; m_locked = 0;
        check("dis_pause_drop", 32'(pause_snes), 32'd0);
        check_stats("dis");
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            hi += int'(pause_snes);
        end
        check("dis_stays_idle", 32'(hi), 32'd0);
        snes_line = 8'd100; snes_refresh = 1'b0;
        enable = 1'b1;
        tick;
        $display("disable mid-pause: last_wait=%0d timeout_cnt=%0d", last_wait, timeout_cnt);
        do_frame(120, 100, "reenable");

        // Reset mid-pause
        snes_line = 8'd2; snes_refresh = 1'b1;
        tick;
        check("rst_pause_rise", 32'(pause_snes), 32'd1);
        repeat (30) tick;
        resetn = 1'b0;
        tick;
        model_reset();
        check_reset_outputs("rst_mid");
        $display("reset mid-pause: pause=%0d last_wait=%0d", pause_snes, last_wait);
        tick;
        snes_line = 8'd100; snes_refresh = 1'b0;
        resetn = 1'b1;
        repeat (4) tick;

        // Early toggle while ARMED must not release the following pause
        hdmi_sof_toggle = ~hdmi_sof_toggle;
        repeat (10) tick;
        check("early_no_pause", 32'(pause_snes), 32'd0);
        do_frame(300, 100, "after_early");
        hdmi_sof_toggle = ~hdmi_sof_toggle;
        repeat (10) tick;
        do_frame(-1, 100, "early_then_none");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
